// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation sequencer and its helpers.
package mont_pkg;

  localparam int unsigned MONT_N       = 512;
  localparam int unsigned MONT_E_WIDTH = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_DONE
  } mexp_state_t;

  typedef enum logic [1:0] {
    OP_TOMONT,
    OP_SQUARE,
    OP_MULT,
    OP_FROMMONT
  } mexp_op_t;

endpackage

// File: rtl/mexp_operand_mux.sv
// Selects the multiplier operand pair for the current square-and-multiply step.
module mexp_operand_mux
  import mont_pkg::*;
#(
  parameter int unsigned N = MONT_N
) (
  input  mexp_op_t       op,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   r2,
  input  logic [N-1:0]   acc,
  input  logic [N-1:0]   xm,
  output logic [N-1:0]   a,
  output logic [N-1:0]   b
);

  always_comb begin
    a = acc;
    b = acc;
    case (op)
      OP_TOMONT: begin
        a = x;
        b = r2;
      end
      OP_SQUARE:   b = acc;
      OP_MULT:     b = xm;
      OP_FROMMONT: b = N'(1);
      default:     b = acc;
    endcase
  end

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery
// multiplier through a clear/start/done handshake, one product at a time.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int unsigned N       = MONT_N,
  parameter int unsigned E_WIDTH = MONT_E_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N-1:0]       in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N-1:0]       in_m,
  input  logic [N-1:0]       in_r,
  input  logic [N-1:0]       in_r2,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               busy,
  output logic               mm_resetn,
  output logic               mm_start,
  output logic [N-1:0]       mm_a,
  output logic [N-1:0]       mm_b,
  output logic [N-1:0]       mm_m,
  input  logic [N-1:0]       mm_result,
  input  logic               mm_done
);

  localparam int unsigned IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  mexp_state_t        state, nextState;
  mexp_op_t           op;
  logic [IW-1:0]      bitIdx;
  logic [N-1:0]       xReg, mReg, r2Reg, acc, xm;
  logic [E_WIDTH-1:0] eReg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = 1'b1;
    done      = 1'b0;
    mm_resetn = 1'b0;
    mm_start  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nextState = S_CLR;
      end
      S_CLR:    nextState = S_LAUNCH;
      S_LAUNCH: begin
        mm_resetn = 1'b1;
        mm_start  = 1'b1;
        nextState = S_WAIT;
      end
      S_WAIT: begin
        mm_resetn = 1'b1;
        if (mm_done) nextState = S_NEXT;
      end
      S_NEXT: begin
        mm_resetn = 1'b1;
        nextState = (op == OP_FROMMONT) ? S_DONE : S_CLR;
      end
      S_DONE: begin
        done      = 1'b1;
        nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  // Every register is cleared so that all outputs, mux-driven ones included, read 0 in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op     <= OP_TOMONT;
      bitIdx <= '0;
      xReg   <= '0;
      eReg   <= '0;
      mReg   <= '0;
      r2Reg  <= '0;
      acc    <= '0;
      xm     <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          xReg   <= in_x;
          eReg   <= in_e;
          mReg   <= in_m;
          r2Reg  <= in_r2;
          acc    <= in_r;
          op     <= OP_TOMONT;
          bitIdx <= IW'(E_WIDTH - 1);
        end
        S_WAIT: if (mm_done) begin
          if (op == OP_TOMONT) xm  <= mm_result;
          else                 acc <= mm_result;
        end
        S_NEXT: begin
          case (op)
            OP_TOMONT: op <= OP_SQUARE;
            OP_SQUARE: begin
              if (eReg[bitIdx])        op <= OP_MULT;
              else if (bitIdx == '0)   op <= OP_FROMMONT;
              else                     bitIdx <= bitIdx - 1'b1;
            end
            OP_MULT: begin
              if (bitIdx == '0) op <= OP_FROMMONT;
              else begin
                op     <= OP_SQUARE;
                bitIdx <= bitIdx - 1'b1;
              end
            end
            OP_FROMMONT: result <= acc;
            default:     op <= OP_TOMONT;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign mm_m = mReg;

  mexp_operand_mux #(.N(N)) uMux (
    .op  (op),
    .x   (xReg),
    .r2  (r2Reg),
    .acc (acc),
    .xm  (xm),
    .a   (mm_a),
    .b   (mm_b)
  );

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Randomized bench: two sequencers (E_WIDTH 8 and 512) against behavioural multipliers and modexp reference.
module tb_mont_exp_ctrl;

  localparam int unsigned N = 512;

  logic           clk;
  logic           resetn;
  logic           start    [2];
  logic [N-1:0]   inX, inM, inR, inR2;
  logic [7:0]     inE8;
  logic [511:0]   inE512;
  logic [N-1:0]   result   [2];
  logic           done     [2];
  logic           busy     [2];
  logic           mmResetn [2];
  logic           mmStart  [2];
  logic [N-1:0]   mmA      [2];
  logic [N-1:0]   mmB      [2];
  logic [N-1:0]   mmM      [2];
  logic [N-1:0]   mmResult [2];
  logic           mmDone   [2];

  int unsigned    mmLat = 5;
  logic           mmRun      [2];
  int unsigned    mmCnt      [2];
  logic [N-1:0]   heldA      [2];
  logic [N-1:0]   heldB      [2];
  int unsigned    startCount [2];
  int unsigned    badStart   [2];
  int unsigned    opChange   [2];

  int unsigned    nChecks = 0;
  int unsigned    nPass   = 0;

  mont_exp_ctrl #(.N(N), .E_WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start[0]),
    .in_x(inX), .in_e(inE8), .in_m(inM), .in_r(inR), .in_r2(inR2),
    .result(result[0]), .done(done[0]), .busy(busy[0]),
    .mm_resetn(mmResetn[0]), .mm_start(mmStart[0]),
    .mm_a(mmA[0]), .mm_b(mmB[0]), .mm_m(mmM[0]),
    .mm_result(mmResult[0]), .mm_done(mmDone[0])
  );

  mont_exp_ctrl #(.N(N), .E_WIDTH(512)) dut512 (
    .clk(clk), .resetn(resetn), .start(start[1]),
    .in_x(inX), .in_e(inE512), .in_m(inM), .in_r(inR), .in_r2(inR2),
    .result(result[1]), .done(done[1]), .busy(busy[1]),
    .mm_resetn(mmResetn[1]), .mm_start(mmStart[1]),
    .mm_a(mmA[1]), .mm_b(mmB[1]), .mm_m(mmM[1]),
    .mm_result(mmResult[1]), .mm_done(mmDone[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a*b*2^-N mod m by plain Montgomery reduction on wide integers
  function automatic logic [N-1:0] montMul(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m);
    logic [2*N+1:0] t;
    t = (2*N+2)'(a) * (2*N+2)'(b);
    for (int unsigned i = 0; i < N; i++) begin
      if (t[0]) t = t + (2*N+2)'(m);
      t = t >> 1;
    end
    if (t >= (2*N+2)'(m)) t = t - (2*N+2)'(m);
    return t[N-1:0];
  endfunction

  // Right-to-left binary exponentiation with ordinary modular products
  function automatic logic [N-1:0] refPow(input logic [N-1:0] x, input logic [511:0] e,
                                          input logic [N-1:0] m, input int unsigned ew);
    logic [2*N-1:0] p;
    logic [N-1:0]   r, base;
    r    = N'(1);
    base = x;
    for (int unsigned i = 0; i < ew; i++) begin
      if (e[i]) begin
        p = ((2*N)'(r) * (2*N)'(base)) % (2*N)'(m);
        r = p[N-1:0];
      end
      p    = ((2*N)'(base) * (2*N)'(base)) % (2*N)'(m);
      base = p[N-1:0];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] rModM(input logic [N-1:0] m);
    logic [N:0] t;
    t = (N+1)'(1);
    for (int unsigned i = 0; i < N; i++) begin
      t = {t[N-1:0], 1'b0};
      if (t >= (N+1)'(m)) t = t - (N+1)'(m);
    end
    return t[N-1:0];
  endfunction

  // Behavioural multipliers: done rises mmLat cycles after the start pulse, held until cleared
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!resetn) begin
        startCount[g] <= 0;
        badStart[g]   <= 0;
        opChange[g]   <= 0;
      end
      if (!mmResetn[g]) begin
        mmRun[g]  <= 1'b0;
        mmCnt[g]  <= 0;
        mmDone[g] <= 1'b0;
        if (mmStart[g] === 1'b1 && resetn) badStart[g] <= badStart[g] + 1;
      end else if (mmStart[g]) begin
        mmRun[g]      <= 1'b1;
        mmCnt[g]      <= 1;
        mmDone[g]     <= (mmLat <= 1);
        mmResult[g]   <= montMul(mmA[g], mmB[g], mmM[g]);
        heldA[g]      <= mmA[g];
        heldB[g]      <= mmB[g];
        startCount[g] <= startCount[g] + 1;
      end else if (mmRun[g] && !mmDone[g]) begin
        mmCnt[g] <= mmCnt[g] + 1;
        if (mmCnt[g] + 1 >= mmLat) mmDone[g] <= 1'b1;
        if (mmA[g] !== heldA[g] || mmB[g] !== heldB[g]) opChange[g] <= opChange[g] + 1;
      end
    end
  end

  task automatic checkVal(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic runExp(input int sel, input string tag, input logic [N-1:0] x,
                        input logic [511:0] e, input logic [N-1:0] m, input logic [N-1:0] r,
                        input logic [N-1:0] r2, input bit midStart);
    int unsigned ew, pop, ops, k, s0, limit;
    logic [N-1:0] expRes;
    ew  = (sel == 0) ? 8 : 512;
    pop = 0;
    for (int unsigned i = 0; i < ew; i++) pop += int'(e[i]);
    ops    = 2 + ew + pop;
    limit  = ops * (mmLat + 3) + 50;
    expRes = refPow(x, e, m, ew);
    @(negedge clk);
    inX = x; inM = m; inR = r; inR2 = r2;
    if (sel == 0) inE8 = e[7:0];
    else          inE512 = e;
    s0 = startCount[sel];
    start[sel] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start[sel] = midStart && (k == 20);
      if (midStart && k == 20) begin
        inX    = x ^ N'(1);
        inE8   = ~inE8;
        inE512 = ~inE512;
      end
      if (k == 2) checkVal({tag, " busy"}, N'(busy[sel]), N'(1));
    end while (!done[sel] && k < limit);
    start[sel] = 1'b0;
    checkVal({tag, " done"}, N'(done[sel]), N'(1));
    checkVal({tag, " result"}, result[sel], expRes);
    checkVal({tag, " latency"}, N'(k + 1), N'(ops * (mmLat + 3) + 2));
    @(negedge clk);
    checkVal({tag, " mm_start count"}, N'(startCount[sel] - s0), N'(ops));
    checkVal({tag, " done pulse"}, N'(done[sel]), N'(0));
    checkVal({tag, " idle"}, N'(busy[sel]), N'(0));
    checkVal({tag, " held"}, result[sel], expRes);
  endtask

  initial begin
    logic [N-1:0]   rm, rx, rr, rr2;
    logic [511:0]   re;
    logic [2*N-1:0] sq;
    int unsigned    k;

    resetn = 1'b0;
    start  = '{1'b0, 1'b0};
    inX = '0; inM = '0; inR = '0; inR2 = '0; inE8 = '0; inE512 = '0;
    repeat (3) @(negedge clk);
    checkVal("reset result", result[0], '0);
    checkVal("reset done", N'(done[0]), '0);
    checkVal("reset busy", N'(busy[0]), '0);
    checkVal("reset mm_resetn", N'(mmResetn[1]), '0);
    checkVal("reset mm_start", N'(mmStart[1]), '0);
    resetn = 1'b1;
    @(negedge clk);
    checkVal("idle mm_resetn", N'(mmResetn[0]), '0);

    runExp(0, "x2e10",  N'(2), 512'(10),   N'(13), N'(9), N'(3), 1'b0);
    runExp(0, "x2eFF",  N'(2), 512'(255),  N'(13), N'(9), N'(3), 1'b0);
    runExp(0, "x7e0",   N'(7), 512'(0),    N'(13), N'(9), N'(3), 1'b0);
    runExp(0, "x5e1",   N'(5), 512'(1),    N'(13), N'(9), N'(3), 1'b0);
    runExp(0, "midstart", N'(6), 512'(90), N'(13), N'(9), N'(3), 1'b1);

    for (int t = 0; t < 4; t++) begin
      mmLat = $urandom_range(2, 7);
      runExp(0, "rand8", N'($urandom_range(0, 12)), 512'($urandom_range(0, 255)),
             N'(13), N'(9), N'(3), 1'b0);
    end
    mmLat = 5;

    // Reset while the first multiplication is in flight
    @(negedge clk);
    inX = N'(2); inE8 = 8'd10; inM = N'(13); inR = N'(9); inR2 = N'(3);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    k = 0;
    while (mmStart[0] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkVal("rst launch seen", N'(mmStart[0]), N'(1));
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkVal("rst result", result[0], '0);
    checkVal("rst done", N'(done[0]), '0);
    checkVal("rst busy", N'(busy[0]), '0);
    checkVal("rst mm_resetn", N'(mmResetn[0]), '0);
    checkVal("rst mm_start", N'(mmStart[0]), '0);
    checkVal("rst mm_a", mmA[0], '0);
    checkVal("rst mm_b", mmB[0], '0);
    checkVal("rst mm_m", mmM[0], '0);
    @(negedge clk);
    checkVal("rst next mm_resetn", N'(mmResetn[0]), '0);
    checkVal("rst next busy", N'(busy[0]), '0);
    resetn = 1'b1;
    runExp(0, "after rst", N'(2), 512'(10), N'(13), N'(9), N'(3), 1'b0);

    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < 16; w++) begin
        rm[32*w +: 32] = $urandom;
        rx[32*w +: 32] = $urandom;
        re[32*w +: 32] = $urandom;
      end
      rm[N-1] = 1'b1;
      rm[0]   = 1'b1;
      rx      = rx % rm;
      rr      = rModM(rm);
      sq      = ((2*N)'(rr) * (2*N)'(rr)) % (2*N)'(rm);
      rr2     = sq[N-1:0];
      runExp(1, "rand512", rx, re, rm, rr, rr2, 1'b0);
    end

    checkVal("mm_start in clear", N'(badStart[0] + badStart[1]), '0);
    checkVal("operands stable", N'(opChange[0] + opChange[1]), '0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
# mont_exp_ctrl

- Sequencer that computes `result = in_x^in_e mod in_m` with left-to-right square-and-multiply.
- It drives the existing `montgomery` multiplier through a reset/start/done handshake, one multiplication at a time, and latches each product as the next operand.
- It sits directly upstream of the multiplier, between the host/RSA top level and the multiplier instance.
- Montgomery constants `R mod M` and `R² mod M` (R = 2^N) are supplied by the host.

## Interface
- `N`, 512, operand/modulus width (must match multiplier).
- `E_WIDTH`, 512, exponent width in bits.

- `clk` in 1, single clock.
- `resetn` in 1, asynchronous, active-low.
- `start` in 1, one-cycle request; sampled only in IDLE.
- `in_x` in N, base, < `in_m`.
- `in_e` in E_WIDTH, exponent.
- `in_m` in N, odd modulus > 1.
- `in_r` in N, R mod M.
- `in_r2` in N, R² mod M.
- `result` out N, exponentiation result; reset 0; held until next accepted `start`.
- `done` out 1, one-cycle pulse when `result` is valid; reset 0.
- `busy` out 1, high from accepted `start` through the `done` cycle; reset 0.
- `mm_resetn` out 1, synchronous reset to multiplier, low = clear; 0 during reset and IDLE.
- `mm_start` out 1, one-cycle start pulse to multiplier; reset 0.
- `mm_a`, `mm_b`, `mm_m` out N, multiplier operands; stable from LAUNCH until `mm_done` is captured.
- `mm_result` in N, multiplier product `a·b·R⁻¹ mod M`.
- `mm_done` in 1, level; stays high until the multiplier is reset.

## Operation
- On accepted `start`, capture `in_x`, `in_e`, `in_m`, `in_r2` into internal registers.
- Load the accumulator `acc` with `in_r`.
- Bit index `i` starts at E_WIDTH-1.
- Op sequence:
  - TOMONT: `xm = MM(x, r2)`.
  - Then for each `i` from E_WIDTH-1 down to 0:
    - SQUARE: `acc = MM(acc, acc)`.
    - If `e[i]` is 1, MULT: `acc = MM(acc, xm)`.
  - Finally FROMMONT: `acc = MM(acc, 1)`; `result <= acc`.
- Leading zero bits are not skipped, so the op count is fixed per exponent: `2 + E_WIDTH + popcount(e)`.
- Operand mux (`mm_m` is always the latched modulus):
  - TOMONT: a=x, b=r2.
  - SQUARE: a=acc, b=acc.
  - MULT: a=acc, b=xm.
  - FROMMONT: a=acc, b=1.
- States:
  - IDLE: `mm_resetn`=0. On `start` → CLR.
  - CLR: `mm_resetn`=0 for exactly one cycle → LAUNCH.
  - LAUNCH: `mm_resetn`=1, `mm_start`=1 for one cycle → WAIT.
  - WAIT: `mm_resetn`=1. On the first cycle with `mm_done`=1, capture `mm_result` into `acc`, or into `xm` for TOMONT → NEXT.
  - NEXT: select the next op, decrementing `i` after MULT or after a SQUARE whose bit is 0.
    - If ops remain → CLR.
    - After FROMMONT → DONE.
  - DONE: `done`=1 for one cycle, `result` updated → IDLE.
- `start` while busy is ignored.
- No `mm_done` timeout; WAIT holds indefinitely.
- `resetn` low at any time: all state to IDLE immediately, outputs to reset values, and `mm_resetn` low so the multiplier is cleared as well.
- Edge cases:
  - `e`=0 gives `result`=1.
  - `e`=1 gives `result`=x.

## Timing
- Per multiplication: 1 (CLR) + 1 (LAUNCH) + L (multiplier latency, start→`mm_done`) + 1 (NEXT).
- Start-to-done latency: 1 + ops·(L+3) + 1 cycles, with ops as above.
- `mm_start` is never asserted in a cycle where `mm_resetn`=0.
- `mm_a`/`mm_b` change only in NEXT/CLR.
- `result` changes only in DONE or on reset.

## Structure
- Shared package `mont_pkg`:
  - state encoding `mexp_state_t` (IDLE, CLR, LAUNCH, WAIT, NEXT, DONE);
  - op encoding `mexp_op_t` (TOMONT, SQUARE, MULT, FROMMONT);
  - parameter defaults for `N`.
- One natural sub-module: `mexp_operand_mux`, the combinational op → (a, b) selector.
- FSM, bit counter and registers stay in the top.

## Test plan
Bench uses a behavioural multiplier model with settable L (default 5) and N=512; unless noted, `in_m`=13, `in_r`=9, `in_r2`=3.

- x=2, e=10 (E_WIDTH=8) → `result`=10, `done` pulse exactly once; count of `mm_start` pulses = 2+8+2 = 12.
- x=2, e=8'hFF → `result`=8; 18 `mm_start` pulses; latency 1+18·8+1 cycles at L=5.
- e=0, x=7 → `result`=1; x=5, e=1 → `result`=5.
- `start` pulsed again mid-run → ignored; the result of the first request is unchanged.
- `resetn` dropped during WAIT → next cycle all outputs 0 and `mm_resetn`=0; a new run after release completes correctly.
- Random 512-bit odd M with Python-computed R, R², E_WIDTH=512 → `result` equals the reference `pow(x, e, M)`.
